// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the
// text-mode character/font stage (slave).
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;

  modport master (
    output pix_en, posx, posy, hsync, vsync, active, line_start, frame_start
  );

  modport slave (
    input  pix_en, posx, posy, hsync, vsync, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, coordinates, and
// sync/active outputs delayed LAT pixels to match the font lookup latency.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_tot
    $error("vga_timing_gen: H_TOT/V_TOT must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in 1..8");
  end

  // 11-bit compare constants so window edges equal to 1024 stay representable
  localparam logic [10:0] HC_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HC_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HC_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VC_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VC_SS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VC_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  HC_LAST = 10'(H_TOT - 1);
  localparam logic [9:0]  VC_LAST = 10'(V_TOT - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        HS_ON  = 1'(HS_POL);
  localparam logic        VS_ON  = 1'(VS_POL);

  logic [3:0]     div_q, div_d;
  logic [9:0]     hcnt_q, hcnt_d;
  logic [9:0]     vcnt_q, vcnt_d;
  logic [LAT-1:0] hs_q, hs_d;
  logic [LAT-1:0] vs_q, vs_d;
  logic [LAT-1:0] act_q, act_d;

  logic        pix_en;
  logic [10:0] hx, vx;
  logic        h_act, v_act;
  logic        hs_raw, vs_raw, act_raw;
  logic        h_wrap;

  always_comb begin
    hx      = {1'b0, hcnt_q};
    vx      = {1'b0, vcnt_q};
    h_act   = hx < HC_ACT;
    v_act   = vx < VC_ACT;
    hs_raw  = (hx >= HC_SS && hx < HC_SE) ? HS_ON : ~HS_ON;
    vs_raw  = (vx >= VC_SS && vx < VC_SE) ? VS_ON : ~VS_ON;
    act_raw = h_act && v_act;
    pix_en  = (div_q == DIV_LAST);
    h_wrap  = (hcnt_q == HC_LAST);

    div_d  = pix_en ? '0 : div_q + 4'd1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    act_d  = act_q;

    if (pix_en) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 10'd1;
      if (h_wrap) begin
        vcnt_d = (vcnt_q == VC_LAST) ? '0 : vcnt_q + 10'd1;
      end
      // cast drops the oldest stage; also covers LAT=1
      hs_d  = LAT'({hs_q,  hs_raw});
      vs_d  = LAT'({vs_q,  vs_raw});
      act_d = LAT'({act_q, act_raw});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      hs_q   <= {LAT{~HS_ON}};
      vs_q   <= {LAT{~VS_ON}};
      act_q  <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      act_q  <= act_d;
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.posx        = h_act ? hcnt_q : '0;
  assign vga.posy        = v_act ? vcnt_q[8:0] : '0;
  assign vga.hsync       = hs_q[LAT-1];
  assign vga.vsync       = vs_q[LAT-1];
  assign vga.active      = act_q[LAT-1];
  assign vga.line_start  = pix_en && (hcnt_q == '0);
  assign vga.frame_start = pix_en && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries run side by side under random
// reset pulses, compared every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if u_if_def ();
  vga_timing_gen_if u_if_sml ();
  vga_timing_gen_if u_if_fst ();

  vga_timing_gen u_dut_def (
    .clk (clk),
    .rst (rst),
    .vga (u_if_def)
  );

  vga_timing_gen #(
    .CLK_DIV (3),
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL  (1),  .VS_POL(1),
    .LAT     (3)
  ) u_dut_sml (
    .clk (clk),
    .rst (rst),
    .vga (u_if_sml)
  );

  vga_timing_gen #(
    .CLK_DIV (1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL  (0),  .VS_POL(0),
    .LAT     (1)
  ) u_dut_fst (
    .clk (clk),
    .rst (rst),
    .vga (u_if_fst)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected output vector c clocks after the last reset edge, derived from
  // the raster position: pixel periods elapsed = c / D.
  function automatic logic [31:0] model(
    input int D, input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input int hp, input int vp, input int lat, input int c);
    int ht, vt, tot, n, p, h, v, q, dh, dv;
    logic pe, ls, fs, hso, vso, act, hpl, vpl;
    logic [9:0] px;
    logic [8:0] py;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    tot = ht * vt;
    n   = c / D;
    p   = n % tot;
    h   = p % ht;
    v   = p / ht;
    hpl = 1'(hp);
    vpl = 1'(vp);
    pe  = (c % D) == (D - 1);
    ls  = pe && (h == 0);
    fs  = pe && (h == 0) && (v == 0);
    px  = (h < ha) ? 10'(h) : 10'd0;
    py  = (v < va) ? 9'(v) : 9'd0;
    if (n >= lat) begin
      q   = (n - lat) % tot;
      dh  = q % ht;
      dv  = q / ht;
      hso = (dh >= ha + hf && dh < ha + hf + hs) ? hpl : ~hpl;
      vso = (dv >= va + vf && dv < va + vf + vs) ? vpl : ~vpl;
      act = (dh < ha) && (dv < va);
    end else begin
      hso = ~hpl;
      vso = ~vpl;
      act = 1'b0;
    end
    return {7'd0, pe, ls, fs, hso, vso, act, py, px};
  endfunction

  function automatic logic [31:0] pack_obs(
    input logic pe, input logic ls, input logic fs, input logic hs,
    input logic vs, input logic act, input logic [8:0] py, input logic [9:0] px);
    return {7'd0, pe, ls, fs, hs, vs, act, py, px};
  endfunction

  int c = 0;
  int ls_cnt = 0;
  int hs_low = 0;
  int act_cnt = 0;
  logic first_run = 1'b1;

  task automatic step_and_check(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    c = r ? 0 : c + 1;

    check_eq("def", pack_obs(u_if_def.pix_en, u_if_def.line_start,
               u_if_def.frame_start, u_if_def.hsync, u_if_def.vsync,
               u_if_def.active, u_if_def.posy, u_if_def.posx),
             model(2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, c));
    check_eq("sml", pack_obs(u_if_sml.pix_en, u_if_sml.line_start,
               u_if_sml.frame_start, u_if_sml.hsync, u_if_sml.vsync,
               u_if_sml.active, u_if_sml.posy, u_if_sml.posx),
             model(3, 20, 3, 4, 5, 12, 2, 2, 3, 1, 1, 3, c));
    check_eq("fst", pack_obs(u_if_fst.pix_en, u_if_fst.line_start,
               u_if_fst.frame_start, u_if_fst.hsync, u_if_fst.vsync,
               u_if_fst.active, u_if_fst.posy, u_if_fst.posx),
             model(1, 16, 2, 3, 3, 8, 1, 2, 2, 0, 0, 1, c));

    // Per-line totals for the default geometry over the first line after reset
    if (first_run && !r && c >= 1 && c <= 1600) begin
      if (u_if_def.line_start) ls_cnt++;
      if (u_if_def.pix_en && !u_if_def.hsync) hs_low++;
      if (u_if_def.pix_en && u_if_def.active) act_cnt++;
      if (c == 1600) begin
        check_eq("line_start_per_line", 32'(ls_cnt), 32'd1);
        check_eq("hsync_low_pixels", 32'(hs_low), 32'd96);
        check_eq("active_pixels", 32'(act_cnt), 32'd640);
        first_run = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step_and_check(1'b1);
    for (int i = 0; i < 5000; i++) step_and_check(1'b0);
    for (int k = 0; k < 20; k++) begin
      int unsigned rlen;
      int unsigned run;
      rlen = $urandom_range(1, 2);
      run  = $urandom_range(1, 2500);
      for (int unsigned i = 0; i < rlen; i++) step_and_check(1'b1);
      for (int unsigned i = 0; i < run; i++) step_and_check(1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
